fifo_uart_tx: RTL

UART transmitter that drains the read side of the team's `FIFO` block and serializes each byte as an 8N1 frame on a single line. It sits between a `FIFO` instance with `WIDTH = 8` and the board TX pin. Producer logic writes bytes into the FIFO. This block pulls them out one at a time and transmits them back-to-back until the FIFO is empty or transmission is disabled.

---
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter draining a FIFO read port; tx_o falls two edges after fifo_rd_en_o when rd_dv follows rd_en by one cycle.
// Backpressure: one byte in flight, fetched only from IDLE when enable_i && !fifo_empty_i; a started frame always completes.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       enable_i,
    input  logic       fifo_empty_i,
    output logic       fifo_rd_en_o,
    input  logic       fifo_rd_dv_i,
    input  logic [7:0] fifo_rd_data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d;
    logic            rd_en_d;
    logic            busy_d;
    logic            done_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            tx_o         <= 1'b1;
            fifo_rd_en_o <= 1'b0;
            busy_o       <= 1'b0;
            tx_done_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            tx_o         <= tx_d;
            fifo_rd_en_o <= rd_en_d;
            busy_o       <= busy_d;
            tx_done_o    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_o;
        rd_en_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                // Empty flag is looked at only here, so its post-read update can't double-fetch.
                if (enable_i && !fifo_empty_i) begin
                    state_d = S_FETCH;
                    rd_en_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (fifo_rd_dv_i) begin
                    shift_d = fifo_rd_data_i;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // shift_q[0] is the bit on the line; the next one sits at [1].
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                tx_d   = 1'b1;
                done_d = (cnt_q == CNT_DONE);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
